// File: rtl/sound_events.sv
// sound_events: CHANNELS independent one-shot (or gated) square-wave tone channels,
// mixed into a 1-bit sound line and a saturating level, both muted in attract mode.
module sound_events #(
  parameter int                        CLK_HZ    = 7_159_000,
  parameter int                        CHANNELS  = 3,
  parameter int                        DIV_W     = 16,
  parameter int                        DUR_W     = 10,
  parameter int                        OUT_W     = 4,
  parameter logic [CHANNELS*DIV_W-1:0] TONE_DIV  = {CHANNELS{16'd3579}},
  parameter logic [CHANNELS*DUR_W-1:0] DUR_MS    = {CHANNELS{10'd240}},
  parameter int                        RETRIGGER = 1
) (
  input  logic                clk7_159,
  input  logic                _reset,
  input  logic [CHANNELS-1:0] _trig,
  input  logic                _attract,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] tone,
  output logic                sound_out,
  output logic [OUT_W-1:0]    level
);

  localparam int             P         = CLK_HZ / 1000;
  localparam int             PW        = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0]  P_LAST    = PW'(P - 1);
  localparam int             LEVEL_MAX = (1 << OUT_W) - 1;

  typedef enum logic {S_IDLE, S_PLAY} chanState_t;

  logic [PW-1:0]       r_msCount;
  logic                w_msTick;
  logic [CHANNELS-1:0] r_trigPrev;
  logic [CHANNELS-1:0] w_start;
  int                  w_popCount;

  // Free-running ms prescaler; deliberately not aligned to events.
  always_ff @(posedge clk7_159 or negedge _reset) begin
    if (!_reset) begin
      r_msCount  <= '0;
      r_trigPrev <= '0;
    end else begin
      r_msCount  <= w_msTick ? '0 : r_msCount + PW'(1);
      r_trigPrev <= _trig;
    end
  end

  assign w_msTick = (r_msCount == P_LAST);
  assign w_start  = r_trigPrev & ~_trig;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    localparam logic [DIV_W-1:0] DIV_RAW  = TONE_DIV[gi*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] DIV_LOAD = (DIV_RAW == '0) ? DIV_W'(1) : DIV_RAW;
    localparam logic [DUR_W-1:0] DUR_LOAD = DUR_MS[gi*DUR_W +: DUR_W];
    localparam bit               GATED    = (DUR_LOAD == '0);

    chanState_t       r_state, w_stateNext;
    logic [DUR_W-1:0] r_dur, w_durNext;
    logic [DIV_W-1:0] r_div, w_divNext;
    logic             r_tone, w_toneNext;

    always_ff @(posedge clk7_159 or negedge _reset) begin
      if (!_reset) begin
        r_state <= S_IDLE;
        r_dur   <= '0;
        r_div   <= '0;
        r_tone  <= 1'b0;
      end else begin
        r_state <= w_stateNext;
        r_dur   <= w_durNext;
        r_div   <= w_divNext;
        r_tone  <= w_toneNext;
      end
    end

    // A retrigger takes priority over a coincident final ms tick, so the channel survives it.
    always_comb begin
      w_stateNext = r_state;
      w_durNext   = r_dur;
      w_divNext   = r_div;
      w_toneNext  = r_tone;
      case (r_state)
        S_IDLE: begin
          if (w_start[gi]) begin
            w_stateNext = S_PLAY;
            w_durNext   = DUR_LOAD;
            w_divNext   = DIV_LOAD;
            w_toneNext  = 1'b0;
          end
        end
        S_PLAY: begin
          if (r_div <= DIV_W'(1)) begin
            w_toneNext = ~r_tone;
            w_divNext  = DIV_LOAD;
          end else begin
            w_divNext  = r_div - DIV_W'(1);
          end
          if (GATED) begin
            if (_trig[gi]) begin
              w_stateNext = S_IDLE;
              w_toneNext  = 1'b0;
            end
          end else if (w_start[gi] && (RETRIGGER != 0)) begin
            w_durNext = DUR_LOAD;
          end else if (w_msTick) begin
            if (r_dur <= DUR_W'(1)) begin
              w_stateNext = S_IDLE;
              w_toneNext  = 1'b0;
            end else begin
              w_durNext = r_dur - DUR_W'(1);
            end
          end
        end
        default: w_stateNext = S_IDLE;
      endcase
    end

    assign busy[gi] = (r_state == S_PLAY);
    assign tone[gi] = r_tone;
  end

  always_comb begin
    w_popCount = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (tone[k] && busy[k]) w_popCount = w_popCount + 1;
    end
  end

  // Attract mode only mutes the mix; the channels keep running underneath.
  always_ff @(posedge clk7_159 or negedge _reset) begin
    if (!_reset) begin
      sound_out <= 1'b0;
      level     <= '0;
    end else begin
      sound_out <= _attract & (|(tone & busy));
      if (!_attract)                   level <= '0;
      else if (w_popCount > LEVEL_MAX) level <= OUT_W'(LEVEL_MAX);
      else                             level <= OUT_W'(w_popCount);
    end
  end

endmodule

// File: tb/tb_sound_events.sv
// tb_sound_events: two sound_events instances (RETRIGGER=1/OUT_W=4 and RETRIGGER=0/OUT_W=1)
// driven by shared stimulus and compared against a time-based behavioural model.
module tb_sound_events;
  localparam int P = 10;

  logic       clk;
  logic       rst_n;
  logic [2:0] trig;
  logic       attract;
  logic [2:0] busyA, toneA, busyB, toneB;
  logic       soundA, soundB;
  logic [3:0] levelA;
  logic [0:0] levelB;

  int checks = 0;
  int errors = 0;

  sound_events #(
    .CLK_HZ(10_000), .CHANNELS(3), .DIV_W(16), .DUR_W(10), .OUT_W(4),
    .TONE_DIV({16'd2, 16'd2, 16'd3}), .DUR_MS({10'd3, 10'd0, 10'd4}), .RETRIGGER(1)
  ) dutA (
    .clk7_159(clk), ._reset(rst_n), ._trig(trig), ._attract(attract),
    .busy(busyA), .tone(toneA), .sound_out(soundA), .level(levelA)
  );

  sound_events #(
    .CLK_HZ(10_000), .CHANNELS(3), .DIV_W(16), .DUR_W(10), .OUT_W(1),
    .TONE_DIV({16'd2, 16'd2, 16'd3}), .DUR_MS({10'd3, 10'd0, 10'd4}), .RETRIGGER(0)
  ) dutB (
    .clk7_159(clk), ._reset(rst_n), ._trig(trig), ._attract(attract),
    .busy(busyB), .tone(toneB), .sound_out(soundB), .level(levelB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel, whether it plays, cycles since entry, ms ticks left.
  bit       mPlay [2][3];
  int       mElap [2][3];
  int       mTicks[2][3];
  bit [2:0] mPrev;
  int       mCycle;
  bit       mSound[2];
  int       mLevel[2];

  function automatic int tdOf(int ch);
    return (ch == 0) ? 3 : 2;
  endfunction

  function automatic int durOf(int ch);
    return (ch == 0) ? 4 : ((ch == 1) ? 0 : 3);
  endfunction

  function automatic bit mToneOf(int inst, int ch);
    return mPlay[inst][ch] && (((mElap[inst][ch] / tdOf(ch)) % 2) == 1);
  endfunction

  function automatic logic [10:0] expA();
    logic [2:0] b, t;
    for (int ch = 0; ch < 3; ch++) begin
      b[ch] = mPlay[0][ch];
      t[ch] = mToneOf(0, ch);
    end
    return {b, t, mSound[0], 4'(mLevel[0])};
  endfunction

  function automatic logic [7:0] expB();
    logic [2:0] b, t;
    for (int ch = 0; ch < 3; ch++) begin
      b[ch] = mPlay[1][ch];
      t[ch] = mToneOf(1, ch);
    end
    return {b, t, mSound[1], 1'(mLevel[1])};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit tick;
    bit st;
    int pop;
    int maxL;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int ch = 0; ch < 3; ch++) begin
          mPlay[i][ch] = 1'b0; mElap[i][ch] = 0; mTicks[i][ch] = 0;
        end
        mSound[i] = 1'b0;
        mLevel[i] = 0;
      end
      mPrev  = 3'b000;
      mCycle = 0;
    end else begin
      tick   = ((mCycle % P) == P - 1);
      mCycle = mCycle + 1;
      for (int i = 0; i < 2; i++) begin
        pop  = 0;
        maxL = (i == 0) ? 15 : 1;
        for (int ch = 0; ch < 3; ch++) if (mToneOf(i, ch)) pop++;
        mSound[i] = attract && (pop > 0);
        mLevel[i] = !attract ? 0 : ((pop > maxL) ? maxL : pop);
        for (int ch = 0; ch < 3; ch++) begin
          st = mPrev[ch] && !trig[ch];
          if (!mPlay[i][ch]) begin
            if (st) begin
              mPlay[i][ch] = 1'b1; mElap[i][ch] = 0; mTicks[i][ch] = durOf(ch);
            end
          end else begin
            mElap[i][ch]++;
            if (durOf(ch) == 0) begin
              if (trig[ch]) mPlay[i][ch] = 1'b0;
            end else if (st && (i == 0)) begin
              mTicks[i][ch] = durOf(ch);
            end else if (tick) begin
              mTicks[i][ch]--;
              if (mTicks[i][ch] == 0) mPlay[i][ch] = 1'b0;
            end
          end
        end
      end
      mPrev = trig;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; trig = 3'b000; attract = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busyA, toneA, soundA, levelA} !== 11'b0) begin
      errors++; $display("FAIL reset_A got=%b want=%b", {busyA, toneA, soundA, levelA}, 11'b0);
    end
    checks++;
    if ({busyB, toneB, soundB, levelB} !== 8'b0) begin
      errors++; $display("FAIL reset_B got=%b want=%b", {busyB, toneB, soundB, levelB}, 8'b0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if ({busyA, busyB} !== 6'b0) begin
        errors++; $display("FAIL held_trig_start got=%b want=%b", {busyA, busyB}, 6'b0);
      end
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL reset_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL reset_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
    end
    trig = 3'b111;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timed();
    int  lenA = 0;
    bit  done = 1'b0;
    trig = 3'b110;
    @(negedge clk);
    trig = 3'b111;
    checks++;
    if (busyA[0] !== 1'b1 || busyB[0] !== 1'b1) begin
      errors++; $display("FAIL timed_busy_next got=%b%b want=11", busyA[0], busyB[0]);
    end
    for (int n = 0; n < 60 && !done; n++) begin
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL timed_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL timed_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
      if (busyA[0]) lenA++;
      else done = 1'b1;
      if (!done) @(negedge clk);
    end
    checks++;
    if (!done || lenA < 31 || lenA > 40) begin
      errors++; $display("FAIL timed_length got=%0d want=31..40 (ended=%0d)", lenA, done);
    end
    checks++;
    if (toneA[0] !== 1'b0) begin
      errors++; $display("FAIL timed_tone_after got=%b want=0", toneA[0]);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_retrigger();
    int fallA = -1;
    int fallB = -1;
    trig = 3'b110;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL retrig_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL retrig_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
      if (!busyA[0] && fallA < 0) fallA = n;
      if (!busyB[0] && fallB < 0) fallB = n;
      if (n == 1 || n == 16) trig[0] = 1'b1;
      if (n == 15) trig[0] = 1'b0;
    end
    checks++;
    if (fallA < 16 + 31 || fallA > 16 + 40) begin
      errors++; $display("FAIL retrig_extend got=%0d want=47..56", fallA);
    end
    checks++;
    if (fallB < 32 || fallB > 41) begin
      errors++; $display("FAIL retrig_ignored got=%0d want=32..41", fallB);
    end
  endtask

  task automatic test_gated();
    int hiA = 0;
    int hiB = 0;
    trig = 3'b101;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL gated_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL gated_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
      if (n <= 50 && busyA[1]) hiA++;
      if (n <= 50 && busyB[1]) hiB++;
      if (n == 51) begin
        checks++;
        if (busyA[1] !== 1'b0 || busyB[1] !== 1'b0) begin
          errors++; $display("FAIL gated_release got=%b%b want=00", busyA[1], busyB[1]);
        end
      end
      if (n == 50) trig = 3'b111;
    end
    checks++;
    if (hiA != 50 || hiB != 50) begin
      errors++; $display("FAIL gated_length got=%0d/%0d want=50/50", hiA, hiB);
    end
  endtask

  task automatic test_mix();
    bit sawThree = 1'b0;
    attract = 1'b1;
    trig = 3'b000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL mix_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL mix_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
      if (levelA == 4'd3) sawThree = 1'b1;
      if (n == 11) begin
        checks++;
        if ({soundA, levelA, soundB, levelB, busyA, busyB} !== {7'b0, 6'b111111}) begin
          errors++; $display("FAIL mix_attract_mute got=%b want=%b",
                             {soundA, levelA, soundB, levelB, busyA, busyB}, {7'b0, 6'b111111});
        end
      end
      if (n == 10) attract = 1'b0;
    end
    checks++;
    if (!sawThree) begin
      errors++; $display("FAIL mix_level3 got=no want=level 3 seen");
    end
    trig = 3'b111;
    attract = 1'b1;
    repeat (45) @(negedge clk);
  endtask

  task automatic test_reset_midplay();
    trig = 3'b010;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      checks++;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL midrst_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if (n == 1) trig = 3'b111;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busyA, toneA, soundA, levelA, busyB, toneB, soundB, levelB} !== 19'b0) begin
      errors++; $display("FAIL midrst_immediate got=%b want=0",
                         {busyA, toneA, soundA, levelA, busyB, toneB, soundB, levelB});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      checks++;
      if ({busyA, busyB} !== 6'b0) begin
        errors++; $display("FAIL midrst_restart got=%b want=%b", {busyA, busyB}, 6'b0);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      checks += 2;
      if ({busyA, toneA, soundA, levelA} !== expA()) begin
        errors++; $display("FAIL random_modelA t=%0t got=%b want=%b", $time, {busyA, toneA, soundA, levelA}, expA());
      end
      if ({busyB, toneB, soundB, levelB} !== expB()) begin
        errors++; $display("FAIL random_modelB t=%0t got=%b want=%b", $time, {busyB, toneB, soundB, levelB}, expB());
      end
      for (int ch = 0; ch < 3; ch++) begin
        if (trig[ch]) trig[ch] = ($urandom_range(11) != 0);
        else          trig[ch] = ($urandom_range(2) == 0);
      end
      if ($urandom_range(39) == 0) attract = ~attract;
    end
  endtask

  initial begin
    rst_n = 1'b0; trig = 3'b000; attract = 1'b1;
    test_reset();
    test_timed();
    test_retrigger();
    test_gated();
    test_mix();
    test_reset_midplay();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
